// File: rtl/seg_capture.sv
// seg_capture: watches a multiplexed active-low 7-segment bus, waits for each
// scanned digit to settle, and decodes the segment pattern back into the
// 5-bit display code. Keeps a per-digit register of the last decoded code.
module seg_capture #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    seg_in,
    input  logic [NUM_DIGITS-1:0]         dig_sel,
    input  logic                          err_clr,
    output logic [5*NUM_DIGITS-1:0]       codes_out,
    output logic [NUM_DIGITS-1:0]         valid_out,
    output logic                          update,
    output logic [$clog2(NUM_DIGITS)-1:0] upd_idx,
    output logic                          err
);

    localparam int         IDX_W    = $clog2(NUM_DIGITS);
    localparam int         SAMP_W   = NUM_DIGITS + 8;
    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] CNT_DONE = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } state_t;

    // True when exactly one digit enable is active.
    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        logic [NUM_DIGITS-1:0] one;
        one = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
        return (v != '0) && ((v & (v - one)) == '0);
    endfunction

    // Position of the active enable; only meaningful for one-hot input.
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Inverse of the segment encoder table: {recognised, code}. 8'hA1 is the
    // shared pattern of codes 13 and 17 and always decodes to 13.
    function automatic logic [5:0] decode_seg(input logic [7:0] p);
        logic [5:0] r;
        case (p)
            8'hC0:   r = {1'b1, 5'd0};
            8'hF9:   r = {1'b1, 5'd1};
            8'hA4:   r = {1'b1, 5'd2};
            8'hB0:   r = {1'b1, 5'd3};
            8'h99:   r = {1'b1, 5'd4};
            8'h92:   r = {1'b1, 5'd5};
            8'h82:   r = {1'b1, 5'd6};
            8'hF8:   r = {1'b1, 5'd7};
            8'h80:   r = {1'b1, 5'd8};
            8'h90:   r = {1'b1, 5'd9};
            8'h88:   r = {1'b1, 5'd10};
            8'h83:   r = {1'b1, 5'd11};
            8'hC6:   r = {1'b1, 5'd12};
            8'hA1:   r = {1'b1, 5'd13};
            8'h86:   r = {1'b1, 5'd14};
            8'h8E:   r = {1'b1, 5'd15};
            8'hAF:   r = {1'b1, 5'd16};
            8'h87:   r = {1'b1, 5'd18};
            8'hF7:   r = {1'b1, 5'd19};
            8'hBF:   r = {1'b1, 5'd20};
            8'hAB:   r = {1'b1, 5'd21};
            8'hFF:   r = {1'b1, 5'd31};
            default: r = {1'b0, 5'd0};
        endcase
        return r;
    endfunction

    logic [7:0]            seg_p0, seg_p1;
    logic [NUM_DIGITS-1:0] dig_sel_p0, dig_sel_p1;
    logic [SAMP_W-1:0]     samp_p2;
    logic [4:0]            codes_q [NUM_DIGITS];
    state_t                state;
    logic [3:0]            cnt;

    logic [SAMP_W-1:0]     samp;
    logic                  samp_same;
    logic                  sel_onehot;
    logic [IDX_W-1:0]      sel_idx;
    logic [5:0]            dec;
    logic                  dec_ok;
    logic [4:0]            dec_code;

    // Two-flop synchronizers for the asynchronous display bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_p0     <= 8'hFF;
            seg_p1     <= 8'hFF;
            dig_sel_p0 <= '0;
            dig_sel_p1 <= '0;
        end else begin
            seg_p0     <= seg_in;
            seg_p1     <= seg_p0;
            dig_sel_p0 <= dig_sel;
            dig_sel_p1 <= dig_sel_p0;
        end
    end

    // Classify the synchronized sample and decode its pattern.
    always_comb begin
        samp       = {dig_sel_p1, seg_p1};
        samp_same  = (samp == samp_p2);
        sel_onehot = is_onehot(dig_sel_p1);
        sel_idx    = onehot_idx(dig_sel_p1);
        dec        = decode_seg(seg_p1);
        dec_ok     = dec[5];
        dec_code   = dec[4:0];
    end

    // Settle FSM plus the code registers it commits into.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            samp_p2   <= {{NUM_DIGITS{1'b0}}, 8'hFF};
            for (int i = 0; i < NUM_DIGITS; i++) codes_q[i] <= 5'd31;
            valid_out <= '0;
            update    <= 1'b0;
            upd_idx   <= '0;
            err       <= 1'b0;
        end else begin
            samp_p2 <= samp;
            update  <= 1'b0;
            if (err_clr) err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_onehot) begin
                        state <= SETTLE;
                        cnt   <= 4'd1;
                    end else begin
                        cnt <= 4'd0;
                    end
                end
                SETTLE: begin
                    if (!sel_onehot) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (!samp_same) begin
                        cnt <= 4'd1;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                        cnt   <= CNT_DONE;
                        if (dec_ok) begin
                            codes_q[sel_idx]   <= dec_code;
                            valid_out[sel_idx] <= 1'b1;
                            if (!valid_out[sel_idx] || codes_q[sel_idx] != dec_code) begin
                                update  <= 1'b1;
                                upd_idx <= sel_idx;
                            end
                        end else begin
                            // Placed after the clear so a new error wins.
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HELD: begin
                    if (!sel_onehot) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (!samp_same) begin
                        state <= SETTLE;
                        cnt   <= 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Flatten the per-digit registers onto the output bus.
    always_comb begin
        codes_out = '0;
        for (int i = 0; i < NUM_DIGITS; i++) codes_out[5*i +: 5] = codes_q[i];
    end

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: table-driven bench for seg_capture with an update scoreboard.
module tb_seg_capture;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic [7:0]   seg_in;
    logic [N-1:0] dig_sel;
    logic         err_clr;
    logic [5*N-1:0] codes_out;
    logic [N-1:0] valid_out;
    logic         update;
    logic [2:0]   upd_idx;
    logic         err;

    seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .err_clr   (err_clr),
        .codes_out (codes_out),
        .valid_out (valid_out),
        .update    (update),
        .upd_idx   (upd_idx),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [4:0] code;
    } exp_t;

    typedef struct {
        logic [N-1:0] dig;
        logic [7:0]   seg;
        int           dwell;
        bit           exp_upd;
        int           slot;
        logic [4:0]   exp_code;
        bit           exp_err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic prev_upd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic [N-1:0] d, input logic [7:0] s, input int dwell);
        dig_sel = d;
        seg_in  = s;
        repeat (dwell) @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] slot_code(input int k);
        return codes_out[5*k +: 5];
    endfunction

    // Scoreboard: every update pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (update) begin
            check("upd_not_back_to_back", prev_upd, 1'b0);
            if (sb.size() == 0) begin
                check("unexpected_update_idx", upd_idx, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_idx", upd_idx, e.idx);
                check("upd_code", codes_out[5*upd_idx +: 5], e.code);
                check("upd_valid", valid_out[upd_idx], 1'b1);
            end
        end
        prev_upd = update;
    end

    initial begin
        logic [5*N-1:0] all31;
        all31   = '1;
        rst_n   = 1'b0;
        dig_sel = '0;
        seg_in  = 8'hFF;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("rst_codes", codes_out, all31);
        check("rst_valid", valid_out, 0);
        check("rst_update", update, 0);
        check("rst_upd_idx", upd_idx, 0);
        check("rst_err", err, 0);

        // First commit: latency from the first sampling edge.
        sb.push_back('{2, 5'd4});
        dig_sel = 6'b000100;
        seg_in  = 8'h99;
        repeat (5) @(posedge clk);
        #1 check("lat_before", update, 0);
        @(posedge clk);
        #1 check("lat_pulse", update, 1);
        check("lat_idx", upd_idx, 2);
        check("lat_code", slot_code(2), 4);
        check("lat_valid", valid_out, 6'b000100);
        @(posedge clk);
        #1 check("lat_after", update, 0);
        repeat (3) @(posedge clk);
        #1;

        vecs.push_back('{6'b000001, 8'h99, 10, 1, 0, 5'd4, 0});
        vecs.push_back('{6'b000100, 8'h99, 10, 0, 2, 5'd4, 0});
        vecs.push_back('{6'b000001, 8'h88, 8, 1, 0, 5'd10, 0});
        vecs.push_back('{6'b000010, 8'hA1, 8, 1, 1, 5'd13, 0});
        vecs.push_back('{6'b000100, 8'hAB, 8, 1, 2, 5'd21, 0});
        vecs.push_back('{6'b001000, 8'hFF, 8, 1, 3, 5'd31, 0});
        vecs.push_back('{6'b010000, 8'hC0, 8, 1, 4, 5'd0, 0});
        vecs.push_back('{6'b100000, 8'hF7, 8, 1, 5, 5'd19, 0});
        vecs.push_back('{6'b000011, 8'h99, 20, 0, 0, 5'd10, 0});
        vecs.push_back('{6'b000010, 8'h00, 10, 0, 1, 5'd13, 1});

        foreach (vecs[i]) begin
            if (vecs[i].exp_upd) sb.push_back('{vecs[i].slot, vecs[i].exp_code});
            apply(vecs[i].dig, vecs[i].seg, vecs[i].dwell);
            check($sformatf("vec%0d_code", i), slot_code(vecs[i].slot), vecs[i].exp_code);
            check($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d_sb_empty", i), sb.size(), 0);
            if (i == 7) check("scan_valid_all", valid_out, 6'h3F);
        end

        // err_clr alone clears; a new error on the clearing edge wins.
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_cleared", err, 0);
        seg_in = 8'h01;
        repeat (5) @(posedge clk);
        #1 check("err_before_commit", err, 0);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check("err_set_wins", err, 1);
        check("err_slot_unchanged", slot_code(1), 13);
        repeat (3) @(posedge clk);
        #1;

        // Glitching pattern never settles long enough to commit.
        for (int g = 0; g < 5; g++) begin
            apply(6'b010000, 8'h92, 2);
            apply(6'b010000, 8'h82, 2);
        end
        check("glitch_code", slot_code(4), 0);
        sb.push_back('{4, 5'd6});
        apply(6'b010000, 8'h82, 10);
        check("glitch_settled", slot_code(4), 6);
        check("glitch_sb_empty", sb.size(), 0);

        // Reset in the middle of settling aborts the commit immediately.
        apply(6'b001000, 8'h99, 3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_codes", codes_out, all31);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_update", update, 0);
        check("mid_rst_upd_idx", upd_idx, 0);
        check("mid_rst_err", err, 0);
        dig_sel = '0;
        seg_in  = 8'hFF;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        apply(6'b000000, 8'hFF, 10);
        check("post_rst_valid", valid_out, 0);
        check("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
